// File: rtl/spectrum_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spectrum_pkg                                                         |
// | Shared constants and the readout FSM state type.                     |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package spectrum_pkg;

    localparam int FFT_POINTS  = 8192;
    localparam int SPEC_ADDR_W = 13;
    localparam int SPEC_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/spectrum_dpram.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spectrum_dpram                                                       |
// | Simple dual-port RAM: one write port, one registered read port.      |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spectrum_dpram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1 << ADDR_W
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        if (i_rd_en) begin
            r_rd_data <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/spectrum_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | spectrum_frame_reader                                                |
// | Ping-pong spectrum frame buffer with valid/ready frame readout.      |
// | Optional peak tracking: define SPEC_PEAK_TRACK_EN.                   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module spectrum_frame_reader
    import spectrum_pkg::*;
#(
    parameter int ADDR_W   = SPEC_ADDR_W,
    parameter int DATA_W   = SPEC_DATA_W,
    parameter int N_POINTS = FFT_POINTS,
    parameter int DROP_W   = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_valid,
    input  logic              rd_req,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              frame_avail,
    output logic              busy,
    output logic [DROP_W-1:0] drop_cnt,
    output logic [DATA_W-1:0] peak_mag,
    output logic [ADDR_W-1:0] peak_bin
);

    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(N_POINTS - 1);
    localparam logic [DROP_W-1:0] c_drop_max  = '1;

    state_t            r_state, w_state_next;
    logic              r_wb;
    logic              r_frame_avail;
    logic [DROP_W-1:0] r_drop_cnt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_pend;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [1:0]        r_cnt;
    logic              r_head;
    logic              r_tail;
    logic [DATA_W-1:0] r_fifo_data [2];
    logic [ADDR_W-1:0] r_fifo_addr [2];
    logic              r_fifo_last [2];

    logic              w_rd_start;
    logic              w_issue;
    logic [ADDR_W-1:0] w_issue_addr;
    logic              w_pop;
    logic              w_final_hs;
    logic [2:0]        w_fill;
    logic              w_frame_done;
    logic              w_reader_holds;
    logic [DATA_W-1:0] w_ram_q;

    spectrum_dpram #(
        .ADDR_W (ADDR_W + 1),
        .DATA_W (DATA_W),
        .DEPTH  (2 * N_POINTS)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (wr_valid),
        .i_wr_addr ({r_wb, wr_addr}),
        .i_wr_data (wr_data),
        .i_rd_en   (w_issue),
        .i_rd_addr ({~r_wb, w_issue_addr}),
        .o_rd_data (w_ram_q)
    );

    assign out_valid   = (r_cnt != 2'd0);
    assign out_data    = r_fifo_data[r_head];
    assign out_addr    = r_fifo_addr[r_head];
    assign out_last    = out_valid && r_fifo_last[r_head];
    assign frame_avail = r_frame_avail;
    assign busy        = (r_state != IDLE);
    assign drop_cnt    = r_drop_cnt;

    assign w_pop      = out_valid && out_ready;
    assign w_final_hs = w_pop && out_last;
    // Occupancy one cycle ahead: a read issued now lands in the FIFO next cycle.
    assign w_fill     = {1'b0, r_cnt} + {2'b00, r_pend} - {2'b00, w_pop};

    always_comb begin
        w_state_next = r_state;
        w_rd_start   = 1'b0;
        w_issue      = 1'b0;
        w_issue_addr = r_rd_ptr;
        case (r_state)
            IDLE: begin
                // The first read goes out with the request to reach 2-cycle latency.
                if (rd_req && r_frame_avail) begin
                    w_rd_start   = 1'b1;
                    w_issue      = 1'b1;
                    w_issue_addr = '0;
                    w_state_next = READ;
                end
            end
            READ: begin
                if (w_fill <= 3'd1) begin
                    w_issue = 1'b1;
                    if (r_rd_ptr == c_last_addr) begin
                        w_state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (w_final_hs) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rd_ptr    <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
        end else begin
            r_state     <= w_state_next;
            r_pend      <= w_issue;
            r_pend_addr <= w_issue_addr;
            if (w_rd_start) begin
                r_rd_ptr <= ADDR_W'(1);
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt          <= 2'd0;
            r_head         <= 1'b0;
            r_tail         <= 1'b0;
            r_fifo_data[0] <= '0;
            r_fifo_data[1] <= '0;
            r_fifo_addr[0] <= '0;
            r_fifo_addr[1] <= '0;
            r_fifo_last[0] <= 1'b0;
            r_fifo_last[1] <= 1'b0;
        end else begin
            if (r_pend) begin
                r_fifo_data[r_tail] <= w_ram_q;
                r_fifo_addr[r_tail] <= r_pend_addr;
                r_fifo_last[r_tail] <= (r_pend_addr == c_last_addr);
                r_tail              <= ~r_tail;
            end
            if (w_pop) begin
                r_head <= ~r_head;
            end
            r_cnt <= r_cnt + {1'b0, r_pend} - {1'b0, w_pop};
        end
    end

    // A reader starting this cycle already owns ~wb, so a completing frame
    // cannot swap into it; a reader finishing this cycle has released it.
    assign w_frame_done   = wr_valid && (wr_addr == c_last_addr);
    assign w_reader_holds = (busy && !w_final_hs) || w_rd_start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wb          <= 1'b0;
            r_frame_avail <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_rd_start) begin
                r_frame_avail <= 1'b0;
            end
            if (w_frame_done && !w_reader_holds) begin
                r_wb          <= ~r_wb;
                r_frame_avail <= 1'b1;
            end
            if (w_frame_done && (w_reader_holds || r_frame_avail) &&
                (r_drop_cnt != c_drop_max)) begin
                r_drop_cnt <= r_drop_cnt + DROP_W'(1);
            end
        end
    end

`ifdef SPEC_PEAK_TRACK_EN
    logic              r_run_any;
    logic [DATA_W-1:0] r_run_mag;
    logic [ADDR_W-1:0] r_run_bin;
    logic [DATA_W-1:0] r_peak_mag;
    logic [ADDR_W-1:0] r_peak_bin;
    logic              w_take;

    // Strictly-greater update keeps the lower bin on ties; DC is skipped.
    assign w_take = w_pop && (out_addr != '0) && (!r_run_any || (out_data > r_run_mag));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run_any  <= 1'b0;
            r_run_mag  <= '0;
            r_run_bin  <= '0;
            r_peak_mag <= '0;
            r_peak_bin <= '0;
        end else begin
            if (w_rd_start) begin
                r_run_any <= 1'b0;
            end else if (w_take) begin
                r_run_any <= 1'b1;
                r_run_mag <= out_data;
                r_run_bin <= out_addr;
            end
            if (w_final_hs) begin
                r_peak_mag <= w_take ? out_data : r_run_mag;
                r_peak_bin <= w_take ? out_addr : r_run_bin;
            end
        end
    end

    assign peak_mag = r_peak_mag;
    assign peak_bin = r_peak_bin;
`else
    assign peak_mag = '0;
    assign peak_bin = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spectrum_frame_reader.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_spectrum_frame_reader                                             |
// | Self-checking bench: vector table, frame-level model, random ready.  |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_spectrum_frame_reader;

    localparam int N     = 8192;
    localparam int AW    = 13;
    localparam int DW    = 16;
    localparam int CLK_P = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] wr_addr = '0;
    logic          wr_valid = 1'b0;
    logic          rd_req = 1'b0;
    logic [DW-1:0] out_data;
    logic [AW-1:0] out_addr;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          out_last;
    logic          frame_avail;
    logic          busy;
    logic [7:0]    drop_cnt;
    logic [DW-1:0] peak_mag;
    logic [AW-1:0] peak_bin;

    spectrum_frame_reader dut (
        .clk         (clk),
        .rst         (rst),
        .wr_data     (wr_data),
        .wr_addr     (wr_addr),
        .wr_valid    (wr_valid),
        .rd_req      (rd_req),
        .out_data    (out_data),
        .out_addr    (out_addr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .frame_avail (frame_avail),
        .busy        (busy),
        .drop_cnt    (drop_cnt),
        .peak_mag    (peak_mag),
        .peak_bin    (peak_bin)
    );

    always #(CLK_P / 2) clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int ready_mode = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: the frame being written, the newest unread
    // complete frame, and the frame currently streaming out.
    logic [DW-1:0] m_cur  [N];
    logic [DW-1:0] m_pend [N];
    logic [DW-1:0] m_rd   [N];
    bit            m_avail = 0;
    bit            m_busy  = 0;
    int            m_drop  = 0;
    int            m_rd_idx = 0;
    int            m_peak_mag = 0;
    int            m_peak_bin = 0;
    int            t_first = 0;
    int            t_last  = 0;

    bit            prev_stall = 0;
    logic [DW-1:0] prev_data;
    logic [AW-1:0] prev_addr;
    logic          prev_last;

    always @(negedge clk) begin
        bit hs, fin, start, holds;
        if (rst) begin
            m_avail = 0; m_busy = 0; m_drop = 0; m_rd_idx = 0;
            m_peak_mag = 0; m_peak_bin = 0; prev_stall = 0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_data", out_data, prev_data);
                chk("hold_addr", out_addr, prev_addr);
                chk("hold_last", out_last, prev_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            prev_last  = out_last;

            hs  = out_valid && out_ready;
            fin = 0;
            if (hs) begin
                checks++;
                if (!m_busy || m_rd_idx >= N) begin
                    failures++;
                    $display("FAIL unexpected_word actual addr=0x%0h required=no word (cycle %0d)", out_addr, cyc);
                end else begin
                    chk("stream_data", out_data, m_rd[m_rd_idx]);
                    chk("stream_addr", out_addr, m_rd_idx);
                    chk("stream_last", out_last, (m_rd_idx == N - 1));
                    if (m_rd_idx == 0) t_first = cyc;
                    if (m_rd_idx == N - 1) begin
                        fin = 1;
                        t_last = cyc;
                    end
                    m_rd_idx++;
                end
            end

            start = rd_req && m_avail && !m_busy;
            holds = (m_busy && !fin) || start;
            if (start) begin
                m_rd = m_pend; m_avail = 0; m_busy = 1; m_rd_idx = 0;
            end
            if (fin) begin
                int pm, pb;
                bit any;
                m_busy = 0;
                pm = 0; pb = 0; any = 0;
                for (int b = 1; b < N; b++) begin
                    if (!any || int'(m_rd[b]) > pm) begin
                        any = 1; pm = int'(m_rd[b]); pb = b;
                    end
                end
                m_peak_mag = pm; m_peak_bin = pb;
            end
            if (wr_valid) m_cur[wr_addr] = wr_data;
            if (wr_valid && wr_addr == AW'(N - 1)) begin
                if (!holds) begin
                    if (m_avail) m_drop++;
                    m_pend  = m_cur;
                    m_avail = 1;
                end else begin
                    m_drop++;
                end
                if (m_drop > 255) m_drop = 255;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 99) >= 30);
        end
    end

    task automatic check_state(input string tag);
        @(posedge clk);
        #2;
        chk({tag, "_avail"}, frame_avail, m_avail);
        chk({tag, "_busy"}, busy, m_busy);
        chk({tag, "_drop"}, drop_cnt, m_drop);
`ifdef SPEC_PEAK_TRACK_EN
        chk({tag, "_peak_mag"}, peak_mag, m_peak_mag);
        chk({tag, "_peak_bin"}, peak_bin, m_peak_bin);
`else
        chk({tag, "_peak_mag"}, peak_mag, 0);
        chk({tag, "_peak_bin"}, peak_bin, 0);
`endif
    endtask

    // kind: 0 ramp, 1 constant 0xAAAA, 2 random, 3 peak pattern
    task automatic write_frame(input int kind);
        for (int a = 0; a < N; a++) begin
            @(posedge clk);
            #1;
            wr_valid = 1'b1;
            wr_addr  = AW'(a);
            case (kind)
                0: wr_data = DW'(a);
                1: wr_data = 16'hAAAA;
                2: wr_data = DW'($urandom);
                default: begin
                    if (a == 0) wr_data = 16'hFFFF;
                    else if (a == 1234 || a == 5000) wr_data = 16'h7000;
                    else wr_data = DW'($urandom_range(0, 16'h6FFF));
                end
            endcase
        end
        @(posedge clk);
        #1;
        wr_valid = 1'b0;
    endtask

    task automatic do_read(input int mode, input bit spam, input int abort_at, input string tag);
        int n;
        ready_mode = mode;
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        chk({tag, "_lat1_valid"}, out_valid, 0);
        chk({tag, "_lat1_busy"}, busy, 1);
        @(negedge clk);
        chk({tag, "_lat2_valid"}, out_valid, 1);
        n = 0;
        while (m_busy && n < 40000) begin
            @(posedge clk);
            #1;
            rd_req = spam && (m_rd_idx < N - 64) && ($urandom_range(0, 63) == 0);
            if (abort_at >= 0 && m_rd_idx >= abort_at) break;
            n++;
        end
        rd_req = 1'b0;
        if (n >= 40000) chk({tag, "_timeout"}, 1, 0);
        if (abort_at < 0 && mode == 0) chk({tag, "_throughput"}, t_last - t_first, N - 1);
    endtask

    typedef struct {
        logic          rd_req;
        logic          wr_valid;
        logic [AW-1:0] wr_addr;
        logic          exp_avail;
        logic          exp_busy;
        logic [7:0]    exp_drop;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #(CLK_P * 150000);
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{1'b1, 1'b0, 13'd0,    1'b0, 1'b0, 8'd0};
        tbl[1] = '{1'b0, 1'b1, 13'd5,    1'b0, 1'b0, 8'd0};
        tbl[2] = '{1'b0, 1'b1, 13'd8191, 1'b1, 1'b0, 8'd0};
        tbl[3] = '{1'b0, 1'b1, 13'd0,    1'b1, 1'b0, 8'd0};
        tbl[4] = '{1'b0, 1'b1, 13'd8191, 1'b1, 1'b0, 8'd1};
        tbl[5] = '{1'b0, 1'b0, 13'd0,    1'b1, 1'b0, 8'd1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_avail", frame_avail, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_peak_mag", peak_mag, 0);
        chk("rst_peak_bin", peak_bin, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Request with nothing available is ignored.
        @(posedge clk);
        #1;
        rd_req = 1'b1;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("noframe_valid", out_valid, 0);
            chk("noframe_busy", busy, 0);
        end

        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            rd_req   = tbl[i].rd_req;
            wr_valid = tbl[i].wr_valid;
            wr_addr  = tbl[i].wr_addr;
            wr_data  = DW'($urandom);
            @(posedge clk);
            #1;
            rd_req   = 1'b0;
            wr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_avail", i), frame_avail, tbl[i].exp_avail);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].exp_busy);
            chk($sformatf("vec%0d_drop", i), drop_cnt, tbl[i].exp_drop);
            chk($sformatf("vec%0d_valid", i), out_valid, 0);
        end

        // Ramp frame, full-rate readout.
        write_frame(0);
        check_state("ramp_written");
        do_read(0, 1'b0, -1, "ramp_full");
        check_state("ramp_done");

        // Ramp under random stalls while a second frame completes mid-readout.
        write_frame(0);
        fork
            begin
                repeat (5) @(posedge clk);
                write_frame(1);
            end
            do_read(1, 1'b1, -1, "ramp_stall");
        join
        check_state("overlap_done");
        chk("overlap_avail_zero", frame_avail, 0);

        // Two frames back to back with no read: only the newer survives.
        write_frame(2);
        write_frame(3);
        check_state("two_frames");
        do_read(0, 1'b0, -1, "newest");
        check_state("newest_done");
`ifdef SPEC_PEAK_TRACK_EN
        chk("peak_mag_pattern", peak_mag, 16'h7000);
        chk("peak_bin_pattern", peak_bin, 1234);
`endif

        // Reset in the middle of a readout.
        write_frame(0);
        do_read(1, 1'b0, 4000, "abort");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_avail", frame_avail, 0);
        chk("abort_last", out_last, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check_state("after_abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/spectrum_frame_reader.md
Name: spectrum_frame_reader

Overview:
- Ping-pong spectrum frame buffer that sits downstream of the FFT magnitude stage.
- Write side takes the magnitude/address/valid write stream, one bin per cycle, 8192 bins per frame.
- Read side streams one complete, stable frame on request over a valid/ready interface to display/peak/UART consumers.
- Write side always gets the bank the reader is not using; the newest completed frame wins.

Parameters:
- ADDR_W, 13, bin address width
- DATA_W, 16, magnitude width
- N_POINTS, 8192, bins per frame; last bin = N_POINTS-1
- DROP_W, 8, width of saturating dropped-frame counter

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- wr_data  in  DATA_W  magnitude from calc stage
- wr_addr  in  ADDR_W  bin index of wr_data
- wr_valid  in  1  write strobe; no backpressure, always accepted
- rd_req  in  1  single-cycle request to stream the available frame
- out_data  out  DATA_W  magnitude
- out_addr  out  ADDR_W  bin index of out_data
- out_valid  out  1  output word valid
- out_ready  in  1  consumer accepts word
- out_last  out  1  marks bin N_POINTS-1
- frame_avail  out  1  unread complete frame in read bank
- busy  out  1  readout in progress
- drop_cnt  out  DROP_W  frames discarded, saturating
- peak_mag  out  DATA_W  see Optional Feature
- peak_bin  out  ADDR_W  see Optional Feature

Behaviour:
- Reset (async, rst=1): wb (write-bank select)=0, frame_avail=0, busy=0, out_valid=0, out_last=0, out_data=0, out_addr=0, drop_cnt=0, peak_mag=0, peak_bin=0. RAM contents are not cleared.
- Write: on wr_valid, store wr_data at {wb, wr_addr}. Addresses are not checked for order; a jump back to 0 mid-frame is simply a resync.
- Frame complete = wr_valid && wr_addr==N_POINTS-1.
- Swap rule on frame complete:
  - Reader not busy: toggle wb and set frame_avail. If frame_avail was already 1, increment drop_cnt (older unread frame discarded).
  - Reader busy: no swap; frame discarded, writer keeps its bank, drop_cnt increments.
- drop_cnt saturates at all-ones.
- Same-cycle frame complete and final handshake (out_valid && out_ready && out_last): the reader releases first, so the swap proceeds.
- FSM states:
  - IDLE: rd_req && frame_avail -> READ. Clear frame_avail, set busy, read pointer=0. rd_req with no frame available is ignored.
  - READ: issue RAM reads on bank ~wb at the pointer into a 2-entry skid FIFO. Never issue a read that would overflow the FIFO counting the 1-cycle RAM latency. Pointer stops after N_POINTS-1 is issued.
  - DRAIN: all reads issued; wait for the final handshake, then -> IDLE and clear busy.
  - rd_req while busy is ignored.
- Output protocol:
  - out_data/out_addr/out_last are held stable while out_valid && !out_ready.
  - First out_valid appears 2 cycles after the rd_req cycle.
  - Throughput is 1 word/cycle with out_ready held high: 8192 words in 8192 consecutive cycles.
  - out_addr increments 0..N_POINTS-1 with no gaps or repeats under arbitrary out_ready patterns.
- Read bank is never written while busy, so a frame is always coherent.
- Reset mid-read: abort immediately to the reset state; out_valid drops asynchronously.

Optional Feature:
- Macro: SPEC_PEAK_TRACK_EN.
- Enabled:
  - During readout, track the maximum out_data among accepted words; ties keep the lower bin.
  - Bin 0 (DC) is excluded.
  - On the final handshake, latch the result into peak_mag/peak_bin; values are held until the next frame completes readout.
- Disabled: peak_mag and peak_bin are tied to 0 and no comparator logic is built.

Decomposition:
- Shared package spectrum_pkg holds:
  - FFT_POINTS=8192, SPEC_ADDR_W=13, SPEC_DATA_W=16
  - FSM state enum {IDLE, READ, DRAIN}
- One sub-module: spectrum_dpram, a simple dual-port RAM with 2*N_POINTS x DATA_W, 1 write port, 1 read port and registered 1-cycle read. The skid FIFO stays inline.

Test Plan:
- Write ramp frame (data=addr), pulse rd_req, out_ready=1 -> out_valid 2 cycles later; out_data 0..8191 contiguous; out_last only on addr 8191; busy low the cycle after.
- Same frame, out_ready random 30% low -> identical sequence, no duplicates or gaps; outputs held while stalled.
- Start readout of frame A, then write frame B (data=0xAAAA) to completion during readout -> all A data intact; drop_cnt=1; frame_avail=0 after read.
- Write frames A then B with no read -> drop_cnt=1; rd_req streams B only.
- rd_req with frame_avail=0 -> no out_valid for 20 cycles; busy stays 0. Assert rst at bin 4000 of a readout -> out_valid=0, busy=0, frame_avail=0 immediately.
- SPEC_PEAK_TRACK_EN: frame with bin0=0xFFFF, bin 1234=0x7000, bin 5000=0x7000 -> peak_mag=0x7000, peak_bin=1234 after out_last.
